// File: rtl/prefetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prefetch_pkg                                                 |
// | Description : Shared types and constants for the OBI prefetch controller.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package prefetch_pkg;

    typedef enum logic [0:0] {
        IDLE        = 1'b0,
        BRANCH_WAIT = 1'b1
    } prefetch_state_e;

    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] FETCH_STRIDE = 32'd4;

endpackage
`default_nettype wire

// File: rtl/prefetch_resp_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prefetch_resp_tracker                                        |
// | Description : Counts in-flight OBI transactions and stale responses, and   |
// |               decides whether each rvalid is pushed or dropped.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module prefetch_resp_tracker
    import prefetch_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   i_accept,
    input  logic                                   i_stale_accept,
    input  logic                                   i_resp_valid,
    input  logic                                   i_branch,
    output logic                                   o_push,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   o_outstanding,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   o_discard
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [OUT_W-1:0] r_outstanding;
    logic [OUT_W-1:0] r_discard;
    logic             w_resp;

    // An rvalid with nothing in flight belongs to no transaction we know of.
    assign w_resp        = i_resp_valid && (r_outstanding != '0);
    assign o_push        = w_resp && (r_discard == '0) && !i_branch;
    assign o_outstanding = r_outstanding;
    assign o_discard     = r_discard;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= r_outstanding + OUT_W'(i_accept) - OUT_W'(w_resp);
            // A redirect turns every older transaction still in flight stale.
            if (i_branch) begin
                r_discard <= r_outstanding - OUT_W'(w_resp) + OUT_W'(i_stale_accept);
            end else begin
                r_discard <= r_discard - OUT_W'(w_resp && (r_discard != '0))
                           + OUT_W'(i_stale_accept);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/prefetch_obi_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prefetch_obi_ctrl                                            |
// | Description : OBI instruction-fetch sequencer: issues word fetches, holds  |
// |               unaccepted requests stable, and handles PC redirects.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module prefetch_obi_ctrl
    import prefetch_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_i,
    input  logic                         branch_i,
    input  logic [31:0]                  branch_addr_i,
    input  logic [$clog2(DEPTH+1)-1:0]   fifo_cnt_i,
    output logic                         trans_valid_o,
    input  logic                         trans_ready_i,
    output logic [31:0]                  trans_addr_o,
    input  logic                         resp_valid_i,
    output logic                         fifo_push_o,
    output logic                         fifo_flush_o,
    output logic                         busy_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int LVL_W = $clog2(DEPTH + MAX_OUTSTANDING + 1);

    prefetch_state_e  r_state;
    logic [31:0]      r_next_addr;
    logic [31:0]      r_branch_addr_q;
    logic             r_held;

    logic [OUT_W-1:0] w_outstanding;
    logic [OUT_W-1:0] w_discard;
    logic             w_push;
    logic [31:0]      w_target;
    logic [31:0]      w_addr_inc;
    logic [CNT_W-1:0] w_eff_cnt;
    logic [LVL_W-1:0] w_level;
    logic             w_issue;
    logic             w_accept;
    logic             w_stale_accept;

    assign w_target  = branch_addr_i & ALIGN_MASK;
    // A redirect flushes the FIFO this cycle, so its occupancy no longer counts.
    assign w_eff_cnt = branch_i ? '0 : fifo_cnt_i;
    assign w_level   = LVL_W'(w_eff_cnt) + LVL_W'(w_outstanding) - LVL_W'(w_discard);

    assign w_issue = rst_n && !r_held && (r_state == IDLE) && req_i
                   && (w_outstanding < OUT_W'(MAX_OUTSTANDING))
                   && (w_level < LVL_W'(DEPTH));

    // While a request is held, r_next_addr is the held address.
    assign trans_valid_o  = rst_n && (r_held || w_issue);
    assign trans_addr_o   = (!r_held && branch_i) ? w_target : r_next_addr;
    assign w_accept       = trans_valid_o && trans_ready_i;
    assign w_addr_inc     = trans_addr_o + FETCH_STRIDE;
    assign w_stale_accept = w_accept && ((r_state == BRANCH_WAIT) || (r_held && branch_i));

    assign fifo_push_o  = rst_n && w_push;
    assign fifo_flush_o = branch_i;
    assign busy_o       = trans_valid_o || (w_outstanding != '0);

    prefetch_resp_tracker #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_resp_tracker (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_accept       (w_accept),
        .i_stale_accept (w_stale_accept),
        .i_resp_valid   (resp_valid_i),
        .i_branch       (branch_i),
        .o_push         (w_push),
        .o_outstanding  (w_outstanding),
        .o_discard      (w_discard)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_next_addr     <= '0;
            r_branch_addr_q <= '0;
            r_held          <= 1'b0;
        end else begin
            r_held <= trans_valid_o && !trans_ready_i;
            case (r_state)
                IDLE: begin
                    if (r_held) begin
                        if (w_accept) begin
                            r_next_addr <= branch_i ? w_target : w_addr_inc;
                        end else if (branch_i) begin
                            r_state         <= BRANCH_WAIT;
                            r_branch_addr_q <= w_target;
                        end
                    end else begin
                        r_next_addr <= w_accept ? w_addr_inc : trans_addr_o;
                    end
                end
                BRANCH_WAIT: begin
                    // The newest redirect target wins, even in the accept cycle.
                    if (w_accept) begin
                        r_state     <= IDLE;
                        r_next_addr <= branch_i ? w_target : r_branch_addr_q;
                    end else if (branch_i) begin
                        r_branch_addr_q <= w_target;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_out_bound: assert property (@(posedge clk) disable iff (!rst_n)
        w_outstanding <= OUT_W'(MAX_OUTSTANDING));
    a_discard_bound: assert property (@(posedge clk) disable iff (!rst_n)
        w_discard <= w_outstanding);
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_push_o |-> (fifo_cnt_i < CNT_W'(DEPTH)));
    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (trans_valid_o && !trans_ready_i) |=> (trans_valid_o && $stable(trans_addr_o)));
    a_stray_resp: assert property (@(posedge clk) disable iff (!rst_n)
        resp_valid_i |-> (w_outstanding != '0))
        else $warning("resp_valid_i with no transaction in flight, ignored");
`endif

endmodule
`default_nettype wire
